// File: rtl/eu_xbuf_mc.sv
// eu_xbuf_mc: multi-channel associative exchange buffer with per-entry read budgets
module eu_xbuf_mc #(
    parameter int NUM_IDX_BITS = 2,
    parameter int NUM_IN_CH    = 2,
    parameter int NUM_RD_PORTS = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int CNT_WIDTH    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_IN_CH-1:0]               in_valid,
    input  logic [NUM_IN_CH*ADDR_WIDTH-1:0]    in_addr,
    input  logic [NUM_IN_CH*DATA_WIDTH-1:0]    in_data,
    input  logic [NUM_IN_CH*CNT_WIDTH-1:0]     in_rd_cnt,
    output logic [NUM_IN_CH-1:0]               in_ready,
    input  logic [NUM_RD_PORTS-1:0]            rd_req,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_hit,
    output logic [NUM_IDX_BITS:0]              occupancy,
    output logic                               full,
    output logic                               empty
);
    localparam int DEPTH = 1 << NUM_IDX_BITS;
    localparam int PW    = NUM_IN_CH > 1 ? $clog2(NUM_IN_CH) : 1;
    localparam int HW    = $clog2(NUM_RD_PORTS + 1);

    logic [DEPTH-1:0]        ent_valid;
    logic [ADDR_WIDTH-1:0]   ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0]   ent_data [DEPTH];
    logic [CNT_WIDTH-1:0]    ent_rem  [DEPTH];
    logic [PW-1:0]           rr_ptr;
    logic [NUM_IN_CH-1:0]    elig;
    logic                    gnt_any;
    logic [PW-1:0]           gnt_idx;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [CNT_WIDTH-1:0]    wr_rem;
    logic [NUM_IDX_BITS-1:0] free_idx;
    logic [HW-1:0]           hit_cnt [DEPTH];
    logic [DEPTH-1:0]        ent_free;
    logic [NUM_IDX_BITS:0]   free_cnt;
    logic [NUM_RD_PORTS-1:0] port_hit;
    logic [DATA_WIDTH-1:0]   port_data [NUM_RD_PORTS];

    // occupancy never exceeds DEPTH, so its MSB alone marks full
    assign full  = occupancy[NUM_IDX_BITS];
    assign empty = ~|occupancy;

    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_IN_CH; c++) begin
            elig[c] = in_valid[c] && !full;
            for (int e = 0; e < DEPTH; e++)
                if (ent_valid[e] && ent_addr[e] == in_addr[c*ADDR_WIDTH +: ADDR_WIDTH]) elig[c] = 1'b0;
        end
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int c = 0; c < NUM_IN_CH; c++)
            if (!gnt_any && elig[c] && c >= int'(rr_ptr)) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(c);
            end
        for (int c = 0; c < NUM_IN_CH; c++)
            if (!gnt_any && elig[c]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(c);
            end
        in_ready = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_rem   = '0;
        for (int c = 0; c < NUM_IN_CH; c++)
            if (gnt_any && gnt_idx == PW'(c)) begin
                in_ready[c] = 1'b1;
                wr_addr = in_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data = in_data[c*DATA_WIDTH +: DATA_WIDTH];
                wr_rem  = in_rd_cnt[c*CNT_WIDTH +: CNT_WIDTH] == '0 ? CNT_WIDTH'(1) : in_rd_cnt[c*CNT_WIDTH +: CNT_WIDTH];
            end
        free_idx = '0;
        for (int e = DEPTH - 1; e >= 0; e--)
            if (!ent_valid[e]) free_idx = NUM_IDX_BITS'(e);
        port_hit = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) port_data[p] = '0;
        for (int e = 0; e < DEPTH; e++) hit_cnt[e] = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++)
            for (int e = 0; e < DEPTH; e++)
                if (rd_req[p] && ent_valid[e] && ent_addr[e] == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    port_hit[p]  = 1'b1;
                    port_data[p] = ent_data[e];
                    hit_cnt[e]   = hit_cnt[e] + 1'b1;
                end
        ent_free = '0;
        free_cnt = '0;
        for (int e = 0; e < DEPTH; e++) begin
            ent_free[e] = hit_cnt[e] != '0 && int'(hit_cnt[e]) >= int'(ent_rem[e]);
            free_cnt = free_cnt + {{NUM_IDX_BITS{1'b0}}, ent_free[e]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            rr_ptr    <= '0;
            occupancy <= '0;
            rd_hit    <= '0;
            rd_data   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_addr[e] <= '0;
                ent_data[e] <= '0;
                ent_rem[e]  <= '0;
            end
        end else begin
            rd_hit <= port_hit;
            for (int p = 0; p < NUM_RD_PORTS; p++)
                if (port_hit[p]) rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= port_data[p];
            for (int e = 0; e < DEPTH; e++)
                if (ent_free[e]) ent_valid[e] <= 1'b0;
                else if (hit_cnt[e] != '0) ent_rem[e] <= ent_rem[e] - CNT_WIDTH'(hit_cnt[e]);
            if (gnt_any) begin
                ent_valid[free_idx] <= 1'b1;
                ent_addr[free_idx]  <= wr_addr;
                ent_data[free_idx]  <= wr_data;
                ent_rem[free_idx]   <= wr_rem;
                rr_ptr <= gnt_idx == PW'(NUM_IN_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
            occupancy <= occupancy + {{NUM_IDX_BITS{1'b0}}, gnt_any} - free_cnt;
        end
    end
endmodule

// File: tb/tb_eu_xbuf_mc.sv
// tb_eu_xbuf_mc: vector table plus randomized queue-model checks for eu_xbuf_mc
module tb_eu_xbuf_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [15:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_rd_cnt;
    logic [1:0]  in_ready;
    logic [1:0]  rd_req;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_hit;
    logic [2:0]  occupancy;
    logic        full;
    logic        empty;
    int checks = 0;
    int failures = 0;

    eu_xbuf_mc dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_rd_cnt(in_rd_cnt), .in_ready(in_ready), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_hit(rd_hit), .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic [15:0] data; int rem; } ent_t;
    ent_t        q[$];
    int          rr;
    logic [1:0]  m_hit;
    logic [15:0] m_data [2];
    logic [1:0]  dut_ready;

    typedef struct {
        logic rst; logic [1:0] v; logic [7:0] a0, a1; logic [15:0] d0, d1; logic [1:0] c0, c1;
        logic [1:0] rq; logic [7:0] r0, r1; logic [1:0] e_rdy, e_hit; logic [15:0] e_d0; logic [2:0] e_occ;
    } vec_t;
    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int find(input logic [7:0] a);
        foreach (q[i]) if (q[i].addr == a) return i;
        return -1;
    endfunction

    function automatic int grant();
        for (int k = 0; k < 2; k++) begin
            int c;
            c = (rr + k) % 2;
            if (in_valid[c] && q.size() < 4 && find(in_addr[c*8 +: 8]) < 0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        rr = 0;
        m_hit = 2'b00;
        m_data[0] = '0;
        m_data[1] = '0;
    endtask

    task automatic idle();
        in_valid = '0; in_addr = '0; in_data = '0; in_rd_cnt = '0; rd_req = '0; rd_addr = '0;
    endtask

    task automatic step();
        int g, idx;
        int hc [4];
        ent_t e;
        logic [1:0] exp_rdy;
        #1;
        g = grant();
        exp_rdy = g < 0 ? 2'b00 : 2'(1 << g);
        dut_ready = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        hc = '{default: 0};
        for (int p = 0; p < 2; p++) begin
            idx = rd_req[p] ? find(rd_addr[p*8 +: 8]) : -1;
            m_hit[p] = idx >= 0;
            if (idx >= 0) begin
                m_data[p] = q[idx].data;
                hc[idx]++;
            end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (hc[i] >= q[i].rem) q.delete(i);
            else begin
                e = q[i];
                e.rem -= hc[i];
                q[i] = e;
            end
        end
        if (g >= 0) begin
            e.addr = in_addr[g*8 +: 8];
            e.data = in_data[g*16 +: 16];
            e.rem  = in_rd_cnt[g*2 +: 2] == 2'd0 ? 1 : int'(in_rd_cnt[g*2 +: 2]);
            q.push_back(e);
            rr = (g + 1) % 2;
        end
        #1;
        chk("rd_hit", 32'(rd_hit), 32'(m_hit));
        chk("rd_data0", 32'(rd_data[15:0]), 32'(m_data[0]));
        chk("rd_data1", 32'(rd_data[31:16]), 32'(m_data[1]));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 4));
        chk("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{0, 2'b01, 8'h12, 8'h00, 16'hBEEF, 16'h0000, 2'd2, 2'd0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 3'd1};
        tbl[1]  = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h12, 8'h00, 2'b00, 2'b01, 16'hBEEF, 3'd1};
        tbl[2]  = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h12, 8'h00, 2'b00, 2'b01, 16'hBEEF, 3'd0};
        tbl[3]  = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h12, 8'h00, 2'b00, 2'b00, 16'h0000, 3'd0};
        tbl[4]  = '{1, 2'b11, 8'h01, 8'h02, 16'h1001, 16'h1002, 2'd1, 2'd1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 3'd1};
        tbl[5]  = '{0, 2'b11, 8'h03, 8'h02, 16'h1003, 16'h1002, 2'd2, 2'd1, 2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 16'h0000, 3'd2};
        tbl[6]  = '{0, 2'b11, 8'h03, 8'h04, 16'h1003, 16'h1004, 2'd2, 2'd1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 3'd3};
        tbl[7]  = '{0, 2'b11, 8'h05, 8'h04, 16'h1005, 16'h1004, 2'd1, 2'd1, 2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 16'h0000, 3'd4};
        tbl[8]  = '{0, 2'b11, 8'h05, 8'h06, 16'h1005, 16'h1006, 2'd1, 2'd1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 3'd4};
        tbl[9]  = '{0, 2'b01, 8'h05, 8'h00, 16'h1005, 16'h0000, 2'd1, 2'd0, 2'b11, 8'h03, 8'h03, 2'b00, 2'b11, 16'h1003, 3'd3};
        tbl[10] = '{0, 2'b01, 8'h05, 8'h00, 16'h1005, 16'h0000, 2'd1, 2'd0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 3'd4};
        tbl[11] = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b11, 8'h01, 8'h02, 2'b00, 2'b11, 16'h1001, 3'd2};
        tbl[12] = '{0, 2'b01, 8'h20, 8'h00, 16'h2020, 16'h0000, 2'd2, 2'd0, 2'b01, 8'h20, 8'h00, 2'b01, 2'b00, 16'h0000, 3'd3};
        tbl[13] = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h20, 8'h00, 2'b00, 2'b01, 16'h2020, 3'd3};
        tbl[14] = '{0, 2'b10, 8'h00, 8'h20, 16'h0000, 16'h3030, 2'd0, 2'd1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 3'd3};
        tbl[15] = '{0, 2'b10, 8'h00, 8'h20, 16'h0000, 16'h3030, 2'd0, 2'd1, 2'b01, 8'h20, 8'h00, 2'b00, 2'b01, 16'h2020, 3'd2};
        tbl[16] = '{0, 2'b10, 8'h00, 8'h20, 16'h0000, 16'h3030, 2'd0, 2'd1, 2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 16'h0000, 3'd3};
        tbl[17] = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h20, 8'h00, 2'b00, 2'b01, 16'h3030, 3'd2};
        tbl[18] = '{0, 2'b01, 8'h30, 8'h00, 16'h4040, 16'h0000, 2'd0, 2'd0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 3'd3};
        tbl[19] = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h30, 8'h00, 2'b00, 2'b01, 16'h4040, 3'd2};
        tbl[20] = '{0, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'd0, 2'd0, 2'b01, 8'h30, 8'h00, 2'b00, 2'b00, 16'h0000, 3'd2};

        idle();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset rd_hit", 32'(rd_hit), 32'h0);
        chk("reset rd_data", rd_data, 32'h0);
        chk("reset occupancy", 32'(occupancy), 32'h0);
        chk("reset empty", 32'(empty), 32'h1);
        chk("reset full", 32'(full), 32'h0);

        for (int i = 0; i < 21; i++) begin
            if (tbl[i].rst) do_reset();
            in_valid  = tbl[i].v;
            in_addr   = {tbl[i].a1, tbl[i].a0};
            in_data   = {tbl[i].d1, tbl[i].d0};
            in_rd_cnt = {tbl[i].c1, tbl[i].c0};
            rd_req    = tbl[i].rq;
            rd_addr   = {tbl[i].r1, tbl[i].r0};
            step();
            chk($sformatf("vec%0d ready", i), 32'(dut_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d hit", i), 32'(rd_hit), 32'(tbl[i].e_hit));
            chk($sformatf("vec%0d occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            if (tbl[i].e_hit[0]) chk($sformatf("vec%0d data0", i), 32'(rd_data[15:0]), 32'(tbl[i].e_d0));
        end

        // a hit is in flight when reset lands between edges
        idle();
        rd_req = 2'b01;
        rd_addr = 16'h0004;
        step();
        chk("pre-reset hit", 32'(rd_hit), 32'h1);
        idle();
        reset = 1'b1;
        #1;
        chk("async rst rd_hit", 32'(rd_hit), 32'h0);
        chk("async rst occupancy", 32'(occupancy), 32'h0);
        chk("async rst empty", 32'(empty), 32'h1);
        chk("async rst rd_data", rd_data, 32'h0);
        reset = 1'b0;
        model_reset();

        for (int n = 0; n < 400; n++) begin
            in_valid = 2'($urandom_range(0, 3));
            for (int c = 0; c < 2; c++) begin
                in_addr[c*8 +: 8]    = 8'($urandom_range(0, 7));
                in_data[c*16 +: 16]  = 16'($urandom);
                in_rd_cnt[c*2 +: 2]  = 2'($urandom_range(0, 3));
            end
            rd_req = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++)
                rd_addr[p*8 +: 8] = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                    q[$urandom_range(0, q.size() - 1)].addr : 8'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eu_xbuf_mc.md
Name: eu_xbuf_mc

Overview:
- Multi-channel, fully associative exchange buffer for an execution unit.
- Accepts operand packets from up to NUM_IN_CH interconnect channels and serves NUM_RD_PORTS ALU read ports by address lookup.
- Each entry carries a read budget; the entry frees itself after that many ALU reads.
- Sits between the interconnect RX side and the ALU operand fetch. Generalises the single-channel, single-reader buffer with has-been-read tracking.

Parameters:
- NUM_IDX_BITS, 2, buffer depth = 2**NUM_IDX_BITS entries
- NUM_IN_CH, 2, number of interconnect input channels
- NUM_RD_PORTS, 2, number of ALU read ports
- ADDR_WIDTH, 8, operand tag/address width
- DATA_WIDTH, 16, operand data width
- CNT_WIDTH, 2, width of per-entry read budget

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  NUM_IN_CH  per-channel packet valid
- in_addr  in  NUM_IN_CH*ADDR_WIDTH  per-channel operand address
- in_data  in  NUM_IN_CH*DATA_WIDTH  per-channel operand data
- in_rd_cnt  in  NUM_IN_CH*CNT_WIDTH  reads before free; 0 is treated as 1
- in_ready  out  NUM_IN_CH  one-hot grant: packet accepted this cycle
- rd_req  in  NUM_RD_PORTS  ALU read request
- rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  requested address
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  registered read data
- rd_hit  out  NUM_RD_PORTS  registered hit flag qualifying rd_data
- occupancy  out  NUM_IDX_BITS+1  number of valid entries
- full  out  1  occupancy == 2**NUM_IDX_BITS
- empty  out  1  occupancy == 0

Behaviour:
- Entry state: valid, addr, data, remaining[CNT_WIDTH].
- Reset (async, active-high): all entries invalid; rd_hit=0; rd_data=0; occupancy=0; empty=1; full=0; round-robin pointer=0. in_ready is combinational, so it is 0 while no valid entry or request qualifies.
- Write acceptance:
  - At most one write per cycle.
  - A channel is eligible when in_valid=1, full=0, and its in_addr matches no valid entry.
  - A round-robin arbiter grants the first eligible channel at or after the pointer. The pointer moves to grant+1 (mod NUM_IN_CH) only when a grant occurs.
  - in_ready is combinational from current state and in_valid. Holding a request until in_ready is the sender's responsibility.
- Write effect:
  - The lowest-index invalid entry is loaded at the clock edge: valid=1, remaining=max(in_rd_cnt,1).
  - The entry is visible to lookups from the next cycle.
  - Two channels presenting the same address in one cycle: only the granted one is accepted. The other becomes ineligible next cycle because its address is now resident.
- Read:
  - Each rd_req port does a combinational associative match against valid entries. rd_hit and rd_data are registered, giving 1-cycle latency.
  - On a miss: rd_hit=0 and rd_data holds its previous value.
  - Several ports hitting one entry in the same cycle each count as one read.
  - remaining decrements by the hit count. When hit count >= remaining, the entry is invalidated at that edge and all of those ports return hit with the data.
- Same-cycle write and read to the same address: the read misses (no bypass).
- A slot freed by reads is not reusable in the same cycle. full is computed from registered occupancy.
- occupancy(next) = occupancy + accepted_write - entries_freed.
- Addresses are unique among valid entries at all times. The eligibility rule guarantees this.
- Reset asserted mid-operation drops all entries and any in-flight read result immediately.

Test Plan:
- Reset, then ch0 writes addr=0x12 data=0xBEEF cnt=2; read 0x12 on port0 for two cycles -> rd_hit=1 and rd_data=0xBEEF on both returns. occupancy goes 1 -> 1 -> 0, and a third read misses.
- ch0 and ch1 both valid every cycle with distinct addresses 0x01..0x04 -> grants alternate ch0, ch1, ch0, ch1. After 4 writes full=1 and in_ready=0 on both channels.
- Buffer full; port0 and port1 both read addr 0x03 (cnt=2) in the same cycle -> both ports hit, the entry frees, and occupancy drops 4 -> 3. A pending ch0 write is granted on the following cycle, not the same one.
- ch0 writes 0x20 and port0 reads 0x20 in the same cycle -> the read misses; a repeat read next cycle hits.
- ch1 offers addr 0x20 while 0x20 is resident with remaining=1 -> in_ready[1]=0. After one read of 0x20, the ch1 write is accepted on the following cycle.
- in_rd_cnt=0 for addr 0x30 -> one read frees the entry. Asserting reset mid-stream clears occupancy to 0 and rd_hit to 0 asynchronously.
